// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the seg_scan_mux scanner.
// DIGIT_W, index-width function and one-hot digit-enable encoder.
package seg_scan_mux_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  // ceil(log2(n)), never less than 1 so a counter always has a bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] i);
    logic [MAX_DIGITS-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Load/ack and display bundle between seg_scan_mux and its user.
// master: drives value/load; slave: drives ack, nibble, digit_en, frame_start.
interface seg_scan_mux_if
  import seg_scan_mux_pkg::*;
#(
  parameter int NDIGITS = 4
);
  logic [DIGIT_W*NDIGITS-1:0] value;
  logic                       load;
  logic                       load_ack;
  logic [DIGIT_W-1:0]         nibble;
  logic [NDIGITS-1:0]         digit_en;
  logic                       frame_start;

  modport master (
    output value, load,
    input  load_ack, nibble, digit_en, frame_start
  );

  modport slave (
    input  value, load,
    output load_ack, nibble, digit_en, frame_start
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scanner.
// Ports: clk, rst (sync high) in; cnt, idx, fb (last cycle of frame) out.
module seg_scan_timer
  import seg_scan_mux_pkg::*;
#(
  parameter  int NDIGITS  = 4,
  parameter  int PRESCALE = 1000,
  localparam int IW       = idx_w(NDIGITS),
  localparam int CW       = idx_w(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          fb
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick;
  logic          last;

  assign tick = (cnt_q == CW'(PRESCALE-1));
  assign last = (idx_q == IW'(NDIGITS-1));
  assign fb   = tick && last;
  assign cnt  = cnt_q;
  assign idx  = idx_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = last ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-seg scanner: frame-aligned value commit, guarded enables.
// Ports: clk, rst (sync high), bus (slave). Option: SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst,
  seg_scan_mux_if.slave bus
);

  localparam int IW = idx_w(NDIGITS);
  localparam int CW = idx_w(PRESCALE);
  localparam int VW = DIGIT_W*NDIGITS;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          fb;

  seg_scan_timer #(
    .NDIGITS  (NDIGITS),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .cnt (cnt),
    .idx (idx),
    .fb  (fb)
  );

  logic [VW-1:0] shadow_q, shadow_d;
  logic [VW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          ack_q, ack_d;
  logic          fs_q;

  // Commit is evaluated before capture so a load on the boundary
  // cycle queues behind the value that is committing.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ack_d    = 1'b0;
    if (fb && pend_v_q) begin
      shadow_d = pend_q;
      pend_v_d = 1'b0;
      ack_d    = 1'b1;
    end
    if (bus.load) begin
      pend_d   = bus.value;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= ack_d;
      fs_q     <= fb;
    end
  end

  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;
  assign bus.nibble      = shadow_q[idx*DIGIT_W +: DIGIT_W];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; once a nonzero nibble is seen,
  // that digit and all below stay lit. Digit 0 is always lit.
  logic [NDIGITS-1:0] mask;
  logic               lit;
  always_comb begin
    mask    = '0;
    mask[0] = 1'b1;
    lit     = 1'b0;
    for (int i = NDIGITS-1; i >= 1; i--) begin
      lit     = lit | (|shadow_q[i*DIGIT_W +: DIGIT_W]);
      mask[i] = lit;
    end
  end
`endif

  logic [MAX_DIGITS-1:0] oh;
  logic [NDIGITS-1:0]    en;
  always_comb begin
    oh = onehot(3'(idx));
    en = oh[NDIGITS-1:0];
    if (rst || (cnt < CW'(GUARD)))
      en = '0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    en = en & mask;
`endif
  end

  assign bus.digit_en = en;

endmodule
